// File: rtl/sent_pkg.sv
// SENT transmit shared definitions: frame states, CRC-4 table, timing constants.
// Used by sent_tx_frame_gen and sent_crc4.
package sent_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    STATUS,
    DATA,
    CRC,
    PAUSE
  } state_t;

  localparam logic [3:0] CRC_SEED = 4'h5;

  localparam int NIBBLE_BASE_TICKS = 12;

  // (i << 4) mod x^4+x^3+x^2+1
  localparam logic [3:0] CRC4T [16] = '{
    4'd0,  4'd13, 4'd7,  4'd10,
    4'd14, 4'd3,  4'd9,  4'd4,
    4'd1,  4'd12, 4'd6,  4'd11,
    4'd15, 4'd2,  4'd8,  4'd5
  };

  function automatic logic [3:0] crc_step(
    input logic [3:0] crc,
    input logic [3:0] nib
  );
    return CRC4T[crc] ^ nib;
  endfunction

endpackage

// File: rtl/sent_crc4.sv
// Serial SENT CRC-4: one data nibble per valid cycle after start,
// then one closing table step; done holds until the next start.
module sent_crc4
  import sent_pkg::*;
#(
  parameter int NUM_DATA = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       valid,
  input  logic [3:0] nibble,
  output logic [3:0] crc,
  output logic       done
);

  logic [2:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (start) begin
      crc  <= CRC_SEED;
      cnt  <= '0;
      done <= 1'b0;
    end else if (valid && !done) begin
      if (cnt == 3'(NUM_DATA)) begin
        crc  <= crc_step(crc, 4'h0);
        done <= 1'b1;
      end else begin
        crc <= crc_step(crc, nibble);
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/sent_tx_frame_gen.sv
// SENT frame encoder: sync, status, data, CRC pulses timed by tick strobes.
// Define SENT_TX_PAUSE_EN to append a PAUSE_TICKS pause pulse after CRC.
module sent_tx_frame_gen
  import sent_pkg::*;
#(
  parameter int NUM_DATA    = 6,
  parameter int LOW_TICKS   = 5,
  parameter int SYNC_TICKS  = 56,
  parameter int PAUSE_TICKS = 12
) (
  input  logic                  clk_tx,
  input  logic                  reset_n_tx,
  input  logic                  ticks_i,
  input  logic                  frame_valid_i,
  output logic                  frame_ready_o,
  input  logic [3:0]            status_i,
  input  logic [4*NUM_DATA-1:0] data_i,
  output logic                  sent_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic [3:0]            crc_o
);

  localparam int DW = 4 * NUM_DATA;
  localparam logic [9:0] LOW_LEN   = 10'(LOW_TICKS);
  localparam logic [9:0] SYNC_LEN  = 10'(SYNC_TICKS);
  localparam logic [9:0] PAUSE_LEN = 10'(PAUSE_TICKS);
  localparam logic [9:0] NIB_BASE  = 10'(NIBBLE_BASE_TICKS);
  localparam logic [2:0] LAST_NIB  = 3'(NUM_DATA - 1);

  state_t          state, state_d;
  logic [9:0]      cnt, cnt_d;
  logic [9:0]      len;
  logic            run, run_d;
  logic [2:0]      idx, idx_d;
  logic [3:0]      status_q, status_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW-1:0]   crc_sh, crc_sh_d;
  logic            sent_q, sent_d;
  logic            done_q, done_d;
  logic            ticks_q;
  logic            tick_stb;
  logic            accept;
  logic            crc_valid;
  logic            crc_done;
  logic [3:0]      crc;

  assign tick_stb  = ticks_i & ~ticks_q;
  assign accept    = frame_valid_i & (state == IDLE);
  assign crc_valid = (state != IDLE) & ~crc_done;

  sent_crc4 #(
    .NUM_DATA (NUM_DATA)
  ) u_crc (
    .clk    (clk_tx),
    .rst_n  (reset_n_tx),
    .start  (accept),
    .valid  (crc_valid),
    .nibble (crc_sh[DW-1 -: 4]),
    .crc    (crc),
    .done   (crc_done)
  );

  always_comb begin
    case (state)
      STATUS:  len = NIB_BASE + {6'd0, status_q};
      DATA:    len = NIB_BASE + {6'd0, data_q[DW-1 -: 4]};
      CRC:     len = NIB_BASE + {6'd0, crc};
      PAUSE:   len = PAUSE_LEN;
      default: len = SYNC_LEN;
    endcase
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    run_d    = run;
    idx_d    = idx;
    status_d = status_q;
    data_d   = data_q;
    crc_sh_d = crc_sh;
    done_d   = 1'b0;
    if (crc_valid) begin
      crc_sh_d = crc_sh << 4;
    end
    if (accept) begin
      state_d  = SYNC;
      cnt_d    = '0;
      run_d    = 1'b0;
      idx_d    = '0;
      status_d = status_i;
      data_d   = data_i;
      crc_sh_d = data_i;
    end else if (state != IDLE && tick_stb) begin
      // first strobe after acceptance opens the sync pulse
      if (!run) begin
        run_d = 1'b1;
        cnt_d = '0;
      end else if (cnt != len - 10'd1) begin
        cnt_d = cnt + 10'd1;
      end else begin
        cnt_d = '0;
        case (state)
          SYNC:   state_d = STATUS;
          STATUS: state_d = DATA;
          DATA: begin
            data_d = data_q << 4;
            if (idx == LAST_NIB) begin
              state_d = CRC;
            end else begin
              idx_d = idx + 3'd1;
            end
          end
`ifdef SENT_TX_PAUSE_EN
          CRC:    state_d = PAUSE;
`endif
          default: begin
            state_d = IDLE;
            run_d   = 1'b0;
            done_d  = 1'b1;
          end
        endcase
      end
    end
    sent_d = !(run_d && (cnt_d < LOW_LEN));
  end

  always_ff @(posedge clk_tx) begin
    if (!reset_n_tx) begin
      state    <= IDLE;
      cnt      <= '0;
      run      <= 1'b0;
      idx      <= '0;
      status_q <= '0;
      data_q   <= '0;
      crc_sh   <= '0;
      sent_q   <= 1'b1;
      done_q   <= 1'b0;
      ticks_q  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      run      <= run_d;
      idx      <= idx_d;
      status_q <= status_d;
      data_q   <= data_d;
      crc_sh   <= crc_sh_d;
      sent_q   <= sent_d;
      done_q   <= done_d;
      ticks_q  <= ticks_i;
    end
  end

  assign sent_o        = sent_q;
  assign frame_done_o  = done_q;
  assign frame_ready_o = (state == IDLE);
  assign busy_o        = (state != IDLE) | done_q;
  assign crc_o         = crc;

endmodule
